// File: rtl/mem_bus_ctrl_pkg.sv
// Shared encodings for the data-side memory bus controller: FSM states,
// default timeout and the access-size codes used by the MEM stage.
package mem_bus_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    DONE   = 2'b10,
    ERR    = 2'b11
  } state_t;

  localparam int DEFAULT_TIMEOUT = 15;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  // One spare bit so the counter can hold TIMEOUT itself without wrapping.
  function automatic int timer_width(input int timeout);
    return $clog2(timeout) + 1;
  endfunction

endpackage

// File: rtl/mem_bus_ctrl_timer.sv
// Saturating wait-state counter; hit flags the last ACCESS cycle allowed
// before the controller declares a bus error.
module bus_timer #(
  parameter int WIDTH = 5,
  parameter int LIMIT = 14
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic hit
);

  logic [WIDTH-1:0] count;

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every always_ff sees the pre-edge values of every other register.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

  assign hit = (count == WIDTH'(LIMIT));

endmodule

// File: rtl/mem_bus_ctrl.sv
// Data-side bus controller: latches one MEM-stage load/store, runs it on the
// external bus with wait states and timeout, and freezes the pipeline meanwhile.
module mem_bus_ctrl
  import mem_bus_ctrl_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dreq,
  input  logic        dwrite,
  input  logic [31:0] daddr,
  input  logic [1:0]  dsize,
  input  logic [31:0] dwdata,
  input  logic        ACKD_n,
  input  logic        ACKI_n,
  input  logic [31:0] ddt_in,
  output logic        MREQ,
  output logic        WRITE,
  output logic [31:0] DAD,
  output logic [1:0]  SIZE,
  output logic        ddt_oe,
  output logic [31:0] ddt_out,
  output logic [31:0] rdata,
  output logic        freeze,
  output logic        bus_err
);

  localparam int CW = timer_width(TIMEOUT);

  state_t state, state_nxt;
  logic   lat_write;
  logic   timer_en, timer_clr, timer_hit;

  bus_timer #(
    .WIDTH(CW),
    .LIMIT(TIMEOUT - 1)
  ) u_timer (
    .clk(clk),
    .rst(rst),
    .en (timer_en),
    .clr(timer_clr),
    .hit(timer_hit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      lat_write <= 1'b0;
      DAD       <= '0;
      SIZE      <= '0;
      ddt_out   <= '0;
      rdata     <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && dreq) begin
        lat_write <= dwrite;
        DAD       <= daddr;
        SIZE      <= dsize;
        ddt_out   <= dwdata;
      end
      // Stores leave rdata untouched so the last load value stays visible.
      if (state == ACCESS && !ACKD_n && !lat_write) begin
        rdata <= ddt_in;
      end
    end
  end

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    timer_en  = 1'b0;
    timer_clr = 1'b0;
    unique case (state)
      IDLE: begin
        if (dreq) begin
          timer_clr = 1'b1;
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        timer_en = ACKD_n;
        // An acknowledge in the final allowed cycle beats the timeout.
        if (!ACKD_n) begin
          state_nxt = DONE;
        end else if (timer_hit) begin
          state_nxt = ERR;
        end
      end
      DONE:    state_nxt = IDLE;
      ERR:     state_nxt = ERR;
      default: state_nxt = IDLE;
    endcase
  end

  assign MREQ    = (state == ACCESS);
  assign WRITE   = MREQ & lat_write;
  assign ddt_oe  = MREQ & lat_write;
  assign bus_err = (state == ERR);
  assign freeze  = ((state == IDLE) & dreq) | (state == ACCESS) | (state == ERR) | ACKI_n;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl: load, store with wait states, timeout,
// ack-at-limit boundary, back-to-back, instruction-wait overlap, mid-access reset.
module tb_mem_bus_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        dreq, dwrite;
  logic [31:0] daddr, dwdata, ddt_in;
  logic [1:0]  dsize;
  logic        ACKD_n, ACKI_n;
  logic        MREQ, WRITE, ddt_oe, freeze, bus_err;
  logic [31:0] DAD, ddt_out, rdata;
  logic [1:0]  SIZE;

  int vectors = 0;
  int miscompares = 0;

  mem_bus_ctrl #(.TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .dreq(dreq), .dwrite(dwrite), .daddr(daddr),
    .dsize(dsize), .dwdata(dwdata), .ACKD_n(ACKD_n), .ACKI_n(ACKI_n),
    .ddt_in(ddt_in), .MREQ(MREQ), .WRITE(WRITE), .DAD(DAD), .SIZE(SIZE),
    .ddt_oe(ddt_oe), .ddt_out(ddt_out), .rdata(rdata), .freeze(freeze),
    .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; dreq = 1'b0; dwrite = 1'b0; daddr = '0; dsize = '0;
    dwdata = '0; ddt_in = '0; ACKD_n = 1'b1; ACKI_n = 1'b0;
    tick(); tick();
    vectors++;
    if ({MREQ, WRITE, ddt_oe, bus_err} !== 4'b0000) begin
      miscompares++; $display("FAIL reset_ctrl: got %b want 0000", {MREQ, WRITE, ddt_oe, bus_err});
    end
    vectors++;
    if ({DAD, SIZE, ddt_out, rdata} !== 98'd0) begin
      miscompares++; $display("FAIL reset_data: got DAD=%h SIZE=%b ddt_out=%h rdata=%h want all 0", DAD, SIZE, ddt_out, rdata);
    end
    rst = 1'b0; ACKI_n = 1'b1; #1;
    vectors++;
    if (freeze !== 1'b1) begin
      miscompares++; $display("FAIL reset_freeze_acki: got %b want 1", freeze);
    end
    ACKI_n = 1'b0; #1;
    vectors++;
    if (freeze !== 1'b0) begin
      miscompares++; $display("FAIL reset_freeze_idle: got %b want 0", freeze);
    end
  endtask

  task automatic test_load();
    int frz = 0;
    dreq = 1'b1; dwrite = 1'b0; daddr = 32'h100; dsize = 2'b10; ACKD_n = 1'b1; #1;
    vectors++;
    if ({freeze, MREQ} !== 2'b10) begin
      miscompares++; $display("FAIL load_idle: got freeze,MREQ=%b want 10", {freeze, MREQ});
    end
    if (freeze) frz++;
    tick();
    ACKD_n = 1'b0; ddt_in = 32'hDEADBEEF; #1;
    if (freeze) frz++;
    vectors++;
    if ({MREQ, WRITE, ddt_oe} !== 3'b100) begin
      miscompares++; $display("FAIL load_access_ctrl: got %b want 100", {MREQ, WRITE, ddt_oe});
    end
    vectors++;
    if (DAD !== 32'h100 || SIZE !== 2'b10) begin
      miscompares++; $display("FAIL load_access_addr: got DAD=%h SIZE=%b want 00000100 10", DAD, SIZE);
    end
    tick();
    ACKD_n = 1'b1; dreq = 1'b0; ddt_in = '0; #1;
    if (freeze) frz++;
    vectors++;
    if (MREQ !== 1'b0 || rdata !== 32'hDEADBEEF) begin
      miscompares++; $display("FAIL load_done: got MREQ=%b rdata=%h want 0 deadbeef", MREQ, rdata);
    end
    vectors++;
    if (frz != 2) begin
      miscompares++; $display("FAIL load_freeze_cycles: got %0d want 2", frz);
    end
    tick();
  endtask

  task automatic test_store_wait();
    int n = 0;
    int wr = 0;
    int data_bad = 0;
    dreq = 1'b1; dwrite = 1'b1; dwdata = 32'h12345678; daddr = 32'h2000;
    dsize = 2'b00; ddt_in = 32'hBAD0BAD0; ACKD_n = 1'b1;
    tick();
    vectors++;
    if (DAD !== 32'h2000 || SIZE !== 2'b00) begin
      miscompares++; $display("FAIL store_addr: got DAD=%h SIZE=%b want 00002000 00", DAD, SIZE);
    end
    for (int c = 0; c < 20 && MREQ; c++) begin
      if (WRITE && ddt_oe) wr++;
      if (ddt_out !== 32'h12345678) data_bad++;
      ACKD_n = (n == 3) ? 1'b0 : 1'b1;
      n++;
      tick();
    end
    ACKD_n = 1'b1; dreq = 1'b0; #1;
    vectors++;
    if (n != 4 || wr != 4) begin
      miscompares++; $display("FAIL store_strobe_cycles: got access=%0d write=%0d want 4 4", n, wr);
    end
    vectors++;
    if (data_bad != 0) begin
      miscompares++; $display("FAIL store_ddt_out: got %0d bad cycles want 0", data_bad);
    end
    vectors++;
    if (rdata !== 32'hDEADBEEF) begin
      miscompares++; $display("FAIL store_rdata_kept: got %h want deadbeef", rdata);
    end
    tick();
  endtask

  task automatic test_timeout();
    int n = 0;
    dreq = 1'b1; dwrite = 1'b0; daddr = 32'h300; dsize = 2'b01; ACKD_n = 1'b1;
    tick();
    dreq = 1'b0; #1;
    for (int c = 0; c < 40 && MREQ; c++) begin
      n++;
      tick();
    end
    vectors++;
    if (n != 15) begin
      miscompares++; $display("FAIL timeout_cycles: got %0d want 15", n);
    end
    tick(); tick(); tick();
    vectors++;
    if ({bus_err, freeze, MREQ, WRITE, ddt_oe} !== 5'b11000) begin
      miscompares++; $display("FAIL timeout_err_sticky: got %b want 11000", {bus_err, freeze, MREQ, WRITE, ddt_oe});
    end
    rst = 1'b1;
    tick();
    rst = 1'b0; #1;
    vectors++;
    if ({bus_err, freeze, MREQ, WRITE, ddt_oe} !== 5'b00000) begin
      miscompares++; $display("FAIL timeout_rst_ctrl: got %b want 00000", {bus_err, freeze, MREQ, WRITE, ddt_oe});
    end
    vectors++;
    if ({DAD, SIZE, ddt_out, rdata} !== 98'd0) begin
      miscompares++; $display("FAIL timeout_rst_data: got DAD=%h SIZE=%b ddt_out=%h rdata=%h want all 0", DAD, SIZE, ddt_out, rdata);
    end
    tick();
    vectors++;
    if (MREQ !== 1'b0 || bus_err !== 1'b0) begin
      miscompares++; $display("FAIL timeout_rst_idle: got MREQ=%b bus_err=%b want 0 0", MREQ, bus_err);
    end
  endtask

  task automatic test_boundary();
    int n = 0;
    dreq = 1'b1; dwrite = 1'b0; daddr = 32'h400; dsize = 2'b10;
    ACKD_n = 1'b1; ddt_in = 32'hCAFEF00D;
    tick();
    for (int c = 0; c < 40 && MREQ; c++) begin
      ACKD_n = (n == 14) ? 1'b0 : 1'b1;
      n++;
      tick();
    end
    ACKD_n = 1'b1; dreq = 1'b0; #1;
    vectors++;
    if (n != 15) begin
      miscompares++; $display("FAIL boundary_cycles: got %0d want 15", n);
    end
    vectors++;
    if (bus_err !== 1'b0 || freeze !== 1'b0 || rdata !== 32'hCAFEF00D) begin
      miscompares++; $display("FAIL boundary_done: got bus_err=%b freeze=%b rdata=%h want 0 0 cafef00d", bus_err, freeze, rdata);
    end
    tick();
    vectors++;
    if (bus_err !== 1'b0 || MREQ !== 1'b0) begin
      miscompares++; $display("FAIL boundary_idle: got bus_err=%b MREQ=%b want 0 0", bus_err, MREQ);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] exp_mreq   = 5'b10010;
    logic [4:0] exp_freeze = 5'b11011;
    dreq = 1'b1; dwrite = 1'b0; daddr = 32'h500; ACKD_n = 1'b0; ddt_in = 32'h0B0B0B0B;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) daddr = 32'h504;
      if (i == 4) dreq = 1'b0;
      #1;
      vectors++;
      if (MREQ !== exp_mreq[i] || freeze !== exp_freeze[i]) begin
        miscompares++; $display("FAIL b2b_cycle%0d: got MREQ=%b freeze=%b want %b %b", i, MREQ, freeze, exp_mreq[i], exp_freeze[i]);
      end
      tick();
    end
    vectors++;
    if (DAD !== 32'h504) begin
      miscompares++; $display("FAIL b2b_second_addr: got %h want 00000504", DAD);
    end
    ACKD_n = 1'b1;
    tick();
  endtask

  task automatic test_overlap();
    logic [4:0] exp_mreq   = 5'b00110;
    logic [4:0] exp_freeze = 5'b01111;
    logic [4:0] acki       = 5'b01100;
    logic [4:0] ackd       = 5'b11011;
    dreq = 1'b1; dwrite = 1'b0; daddr = 32'h600; ddt_in = 32'h600D600D;
    for (int i = 0; i < 5; i++) begin
      ACKI_n = acki[i];
      ACKD_n = ackd[i];
      if (i >= 3) dreq = 1'b0;
      #1;
      vectors++;
      if (MREQ !== exp_mreq[i] || freeze !== exp_freeze[i]) begin
        miscompares++; $display("FAIL overlap_cycle%0d: got MREQ=%b freeze=%b want %b %b", i, MREQ, freeze, exp_mreq[i], exp_freeze[i]);
      end
      tick();
    end
    ACKI_n = 1'b0; ACKD_n = 1'b1;
    vectors++;
    if (rdata !== 32'h600D600D) begin
      miscompares++; $display("FAIL overlap_rdata: got %h want 600d600d", rdata);
    end
  endtask

  task automatic test_reset_mid();
    dreq = 1'b1; dwrite = 1'b0; daddr = 32'h700; ACKD_n = 1'b1;
    tick();
    tick();
    rst = 1'b1; ACKD_n = 1'b0; ddt_in = 32'h11111111; #1;
    vectors++;
    if (MREQ !== 1'b1) begin
      miscompares++; $display("FAIL rstmid_in_access: got MREQ=%b want 1", MREQ);
    end
    tick();
    rst = 1'b0; dreq = 1'b0; ACKD_n = 1'b1; #1;
    vectors++;
    if (MREQ !== 1'b0 || rdata !== 32'h0 || DAD !== 32'h0 || freeze !== 1'b0) begin
      miscompares++; $display("FAIL rstmid_released: got MREQ=%b rdata=%h DAD=%h freeze=%b want 0 0 0 0", MREQ, rdata, DAD, freeze);
    end
    tick();
    vectors++;
    if (MREQ !== 1'b0 || rdata !== 32'h0) begin
      miscompares++; $display("FAIL rstmid_idle: got MREQ=%b rdata=%h want 0 0", MREQ, rdata);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_store_wait();
    test_timeout();
    test_boundary();
    test_back_to_back();
    test_overlap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
